// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver: time-slices NUM_DIGITS digits, double-buffers
// the displayed value so updates only land at frame boundaries.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter bit HEX_MODE    = 1'b0,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic                    blank,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(REFRESH_DIV - 1);
  localparam logic [7:0]            SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ACTIVE_LOW ? '1 : '0;

  // Low-true glyph for a digit code with the dp segment left dark.
  function automatic logic [7:0] glyph_lo(input logic [3:0] code);
    case (code)
      4'h0: return 8'h03;
      4'h1: return 8'h9F;
      4'h2: return 8'h25;
      4'h3: return 8'h0D;
      4'h4: return 8'h99;
      4'h5: return 8'h49;
      4'h6: return 8'h41;
      4'h7: return 8'h1F;
      4'h8: return 8'h01;
      4'h9: return 8'h09;
      4'hA: return HEX_MODE ? 8'h11 : 8'hFF;
      4'hB: return HEX_MODE ? 8'hC1 : 8'hFF;
      4'hC: return HEX_MODE ? 8'h63 : 8'hFF;
      4'hD: return HEX_MODE ? 8'h85 : 8'hFF;
      4'hE: return HEX_MODE ? 8'h61 : 8'hFF;
      default: return HEX_MODE ? 8'h71 : 8'hFF;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [4*NUM_DIGITS-1:0] pend_val_p0;
  logic [NUM_DIGITS-1:0]   pend_dp_p0;
  logic                    pending_p0;
  logic [4*NUM_DIGITS-1:0] act_val_p0;
  logic [NUM_DIGITS-1:0]   act_dp_p0;
  logic                    tick;
  logic                    wrap;

  assign tick = (cnt_p0 == LAST_CNT);
  assign wrap = tick && (idx_p0 == LAST_IDX);

  // Stage p0: slot counter, digit index and frame pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_p0     <= '0;
      idx_p0     <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt_p0 <= tick ? '0 : cnt_p0 + 1'b1;
      if (tick) begin
        idx_p0 <= wrap ? '0 : idx_p0 + 1'b1;
      end
      frame_done <= wrap;
    end
  end

  // A load coinciding with the wrap bypasses the pending buffer so it is not lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_val_p0 <= '0;
      pend_dp_p0  <= '0;
      pending_p0  <= 1'b0;
      act_val_p0  <= '0;
      act_dp_p0   <= '0;
    end else begin
      if (load) begin
        pend_val_p0 <= value;
        pend_dp_p0  <= dp_mask;
      end
      if (wrap) begin
        pending_p0 <= 1'b0;
        if (load) begin
          act_val_p0 <= value;
          act_dp_p0  <= dp_mask;
        end else if (pending_p0) begin
          act_val_p0 <= pend_val_p0;
          act_dp_p0  <= pend_dp_p0;
        end
      end else if (load) begin
        pending_p0 <= 1'b1;
      end
    end
  end

  logic [4*NUM_DIGITS-1:0] upper;
  logic [NUM_DIGITS-1:0]   onehot;
  logic                    lead_zero;
  logic                    dp_on;
  logic [7:0]              seg_lo;
  logic [NUM_DIGITS-1:0]   an_lo;

  // Digits from the current index upward all zero means this digit is a leading zero.
  always_comb begin
    upper     = act_val_p0 >> {idx_p0, 2'b00};
    onehot    = NUM_DIGITS'(1) << idx_p0;
    lead_zero = lz_blank && (idx_p0 != '0) && (upper == '0);
    dp_on     = |(act_dp_p0 & onehot);
    seg_lo    = lead_zero ? 8'hFF : glyph_lo(upper[3:0]);
    if (dp_on) begin
      seg_lo[0] = 1'b0;
    end
    an_lo     = ~onehot;
  end

  // Stage p1: registered segment and anode drive
  always_ff @(posedge CLK) begin
    if (RST) begin
      SEG <= SEG_OFF;
      AN  <= AN_OFF;
    end else if (blank) begin
      SEG <= SEG_OFF;
      AN  <= AN_OFF;
    end else begin
      SEG <= ACTIVE_LOW ? seg_lo : ~seg_lo;
      AN  <= ACTIVE_LOW ? an_lo : ~an_lo;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: CLK cycles per digit slot, legal >= 2.
REQ-003 SHALL have parameter HEX_MODE, default 0: 1 = codes 10..15 drive hex glyphs; 0 = codes 10..15 blank.
REQ-004 SHALL have parameter ACTIVE_LOW, default 1: 1 = SEG and AN are driven low-true.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 CLK  input  1  rising-edge clock for all state.
REQ-007 RST  input  1  synchronous, active-high reset.
REQ-008 value  input  4*NUM_DIGITS  digit codes; nibble k drives digit k, where digit 0 is least significant.
REQ-009 dp_mask  input  NUM_DIGITS  decimal-point enables, bit k drives digit k; sampled with value.
REQ-010 load  input  1  single-cycle strobe that captures value and dp_mask.
REQ-011 lz_blank  input  1  level input that enables leading-zero blanking.
REQ-012 blank  input  1  level input that forces the display dark.
REQ-013 SEG  output  8  segments {a,b,c,d,e,f,g,dp}, with SEG[7]=a and SEG[0]=dp; registered.
REQ-014 AN  output  NUM_DIGITS  digit enables, one-hot when lit; registered.
REQ-015 frame_done  output  1  one-cycle pulse when digit index wraps to 0.

Function
REQ-016 Slot counter SHALL count 0..REFRESH_DIV-1 and wrap; tick SHALL be asserted when the count equals REFRESH_DIV-1.
REQ-017 On tick, digit index idx SHALL advance idx+1, wrapping NUM_DIGITS-1 -> 0.
REQ-018 SEG and AN SHALL both be registered from the current idx and active buffer, so they change on the same edge, one cycle after idx changes.
REQ-019 frame_done SHALL pulse for one cycle, coincident with the idx 0 edge, whenever idx wraps NUM_DIGITS-1 -> 0.
REQ-020 On load, value/dp_mask SHALL be written to a pending buffer and the pending flag SHALL be set; repeated loads SHALL overwrite, so the newest load wins.
REQ-021 On a wrap tick with pending set, pending SHALL copy to the active buffer and pending SHALL clear, giving tear-free updates at frame boundaries only.
REQ-022 If load and the wrap tick occur in the same cycle, the active buffer SHALL take the load-cycle value directly and pending SHALL clear.
REQ-023 Glyphs (ACTIVE_LOW=1, dp off) SHALL be: 0=03 1=9F 2=25 3=0D 4=99 5=49 6=41 7=1F 8=01 9=09 (hex).
REQ-024 HEX_MODE=1 glyphs SHALL be: A=11 b=C1 C=63 d=85 E=61 F=71; with HEX_MODE=0, codes 10..15 SHALL give an all-off glyph (FF).
REQ-025 The dp segment SHALL be lit, SEG[0] active, when the dp_mask bit for the current digit is 1, including on blanked digits.
REQ-026 Leading-zero blanking, when lz_blank=1: digit k SHALL be blanked if its code and every higher-digit code are 0, with k>0; digit 0 SHALL never be leading-blanked.
REQ-027 A blanked digit SHALL drive all segments off except dp per REQ-025, and its AN SHALL stay active.
REQ-028 With blank=1, all AN SHALL be inactive and SEG SHALL be all-off from the next edge, while scan counters keep running.
REQ-029 ACTIVE_LOW=0 SHALL bitwise invert the SEG and AN encodings.
REQ-030 NUM_DIGITS=1 SHALL wrap idx every tick, so frame_done pulses on every tick.

Reset
REQ-031 While RST=1, the slot counter and idx SHALL be 0, the active and pending buffers SHALL be 0, pending flag and frame_done SHALL be 0, AN SHALL be all inactive and SEG all-off (FF for ACTIVE_LOW=1).
REQ-032 RST asserted mid-frame or with pending set SHALL discard the pending data; the first AN enable SHALL occur on the first edge after RST deasserts, with digit 0 showing 0.
REQ-033 RST SHALL take priority over load and blank.

Verification
REQ-034 NUM_DIGITS=4, REFRESH_DIV=4, load value=16'h1234 -> after the next wrap, AN cycles E,D,B,7 every 4 clocks with SEG 99,0D,25,9F respectively.
REQ-035 load 16'h0007, lz_blank=1 -> digits 3..1 show FF with AN active, and digit 0 shows 1F.
REQ-036 HEX_MODE=0, value=16'hABCD, dp_mask=4'b0001 -> digits 3..1 show FF, and digit 0 shows FE (blank glyph with dp lit).
REQ-037 load 16'h1111 mid-frame, then load 16'h2222 before the wrap -> no 1111 is ever displayed; 2222 (SEG 25) appears starting at the idx 0 slot.
REQ-038 load asserted on the wrap tick cycle with 16'h0909 -> the idx 0 slot immediately shows 09, and frame_done pulses once.
REQ-039 Assert RST during idx=2 with pending set -> next edge gives AN=F, SEG=FF; after release, digit 0 shows 03 and previous data never reappears.
